dmem_responder: RTL

- Memory-side responder for CPU load/store traffic (lw/sw).
- Accepts one word request at a time over a valid/ready request channel.
- Inserts a programmable number of wait states, then returns read data or write acknowledge over a valid/ready response channel.
- Used when the datapath moves from ideal single-cycle data memory to a stalling memory port; holds byte-addressed, big-endian storage.

---
 rtl/dmem_responder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: big-endian word load/store responder with wait states.
// Define DMEM_RSP_ERR_EN to reject misaligned or out-of-range requests.
module dmem_responder #(
   parameter int DEPTH_BYTES = 128,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        ReqValid,
   output logic        ReqReady,
   input  logic        ReqWr,
   input  logic [31:0] ReqAddr,
   input  logic [31:0] ReqWData,
   output logic        RspValid,
   input  logic        RspReady,
   output logic [31:0] RspData,
   output logic        RspErr
);
   localparam int AW = (DEPTH_BYTES > 4) ? $clog2(DEPTH_BYTES) : 2;
   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          lat_wr;
   logic [AW-1:0] lat_idx;
   logic [31:0]   lat_wdata;
   logic [7:0]    mem [DEPTH_BYTES];

   logic [31:0]   word_addr;
   logic [AW-1:0] req_idx;
   logic          req_err;
   logic          accept;
   logic          acc_en;
   logic          acc_wr;
   logic [AW-1:0] acc_idx;
   logic [31:0]   acc_wdata;
   logic [31:0]   rd_word;

`ifdef DMEM_RSP_ERR_EN
   assign req_err = (ReqAddr[1:0] != 2'b00)
                 || (ReqAddr > 32'(DEPTH_BYTES - 4));
   assign word_addr = ReqAddr;
`else
   // Without checking, wrap into storage and drop the byte offset.
   assign req_err = 1'b0;
   assign word_addr = (ReqAddr % 32'(DEPTH_BYTES)) & ~32'd3;
`endif

   assign req_idx = AW'(word_addr);
   assign accept  = ReqValid && ReqReady;

   // The access happens on the edge that enters RESP; in IDLE with
   // zero wait states that is the accepting edge, so use live inputs.
   always_comb begin
      acc_en    = 1'b0;
      acc_wr    = lat_wr;
      acc_idx   = lat_idx;
      acc_wdata = lat_wdata;
      unique case (state)
         IDLE: begin
            acc_wr    = ReqWr;
            acc_idx   = req_idx;
            acc_wdata = ReqWData;
            acc_en    = accept && !req_err && (WAIT_CYCLES == 0);
         end
         WAIT:    acc_en = (cnt == '0);
         default: acc_en = 1'b0;
      endcase
   end

   assign rd_word = {mem[acc_idx],
                     mem[acc_idx + AW'(1)],
                     mem[acc_idx + AW'(2)],
                     mem[acc_idx + AW'(3)]};

   // Storage is not reset; a reset on the commit edge blocks the write.
   always_ff @(posedge CLK) begin
      if (acc_en && acc_wr && Reset) begin
         mem[acc_idx]         <= acc_wdata[31:24];
         mem[acc_idx + AW'(1)] <= acc_wdata[23:16];
         mem[acc_idx + AW'(2)] <= acc_wdata[15:8];
         mem[acc_idx + AW'(3)] <= acc_wdata[7:0];
      end
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state     <= IDLE;
         cnt       <= '0;
         ReqReady  <= 1'b0;
         RspValid  <= 1'b0;
         RspData   <= '0;
         RspErr    <= 1'b0;
         lat_wr    <= 1'b0;
         lat_idx   <= '0;
         lat_wdata <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               ReqReady <= 1'b1;
               if (accept) begin
                  ReqReady  <= 1'b0;
                  lat_wr    <= ReqWr;
                  lat_idx   <= req_idx;
                  lat_wdata <= ReqWData;
                  if (req_err) begin
                     state    <= RESP;
                     RspValid <= 1'b1;
                     RspErr   <= 1'b1;
                     RspData  <= '0;
                  end else if (WAIT_CYCLES == 0) begin
                     state    <= RESP;
                     RspValid <= 1'b1;
                     RspErr   <= 1'b0;
                     RspData  <= ReqWr ? 32'd0 : rd_word;
                  end else begin
                     state <= WAIT;
                     cnt   <= CW'(WAIT_CYCLES - 1);
                  end
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state    <= RESP;
                  RspValid <= 1'b1;
                  RspErr   <= 1'b0;
                  RspData  <= lat_wr ? 32'd0 : rd_word;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (RspReady) begin
                  state    <= IDLE;
                  RspValid <= 1'b0;
                  RspErr   <= 1'b0;
                  RspData  <= '0;
                  ReqReady <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               ReqReady <= 1'b0;
               RspValid <= 1'b0;
            end
         endcase
      end
   end
endmodule
